seq_detect_fsm: RTL and testbench

- Parametrised serial pattern-detector FSM, fed one bit at a time by the SPI receive path (i_Data qualified by i_Data_Vld).
- Detects a runtime-programmable PAT_W-bit pattern in the bit stream, MSB first.
- Supports overlapping and non-overlapping detection.
- Reports its FSM state, emits a registered match pulse and keeps a saturating match count.

---
 rtl/seq_detect_fsm.sv | 140 ++++++++++++++
 tb/tb_seq_detect_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_fsm
// Description : Serial pattern detector for the SPI receive path. Shifts in
//               one bit per valid cycle (MSB first) and compares the last
//               PAT_W bits against a runtime-programmable pattern. Supports
//               overlapping and non-overlapping detection. Reports its FSM
//               state, a one-cycle registered match pulse and a saturating
//               match count.
// Optional    : define SEQ_DETECT_MASK_EN to add i_Mask. Bits set in i_Mask
//               are don't-care in the compare.
// Ports       : i_Clk        - clock, all logic on posedge
//               i_Rst        - asynchronous reset, active-low
//               i_Clear      - synchronous clear of window/fill/count/state
//               i_Data       - received serial bit
//               i_Data_Vld   - i_Data is valid this cycle
//               i_Pattern    - target pattern (bit PAT_W-1 = earliest bit)
//               i_Mask       - don't-care mask (SEQ_DETECT_MASK_EN only)
//               i_Overlap    - 1 = overlapping, 0 = non-overlapping
//               o_State      - IDLE=00, FILL=01, HUNT=10, MATCH=11
//               o_Match      - one-cycle pulse per detected match
//               o_Match_Cnt  - saturating match count since reset/clear
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_fsm #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Clear,
    input  logic             i_Data,
    input  logic             i_Data_Vld,
    input  logic [PAT_W-1:0] i_Pattern,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_W-1:0] i_Mask,
`endif
    input  logic             i_Overlap,
    output logic [1:0]       o_State,
    output logic             o_Match,
    output logic [CNT_W-1:0] o_Match_Cnt
);

    // Fill counter must hold the value PAT_W itself.
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] c_fill_full = FW'(PAT_W);
    localparam logic [FW-1:0] c_fill_one  = FW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_HUNT  = 2'b10,
        ST_MATCH = 2'b11
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_window;
    logic [FW-1:0]    r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_window_next;
    logic [FW-1:0]    w_fill_next;
    logic [PAT_W-1:0] w_diff;
    logic             w_hit;

    assign w_window_next = {r_window[PAT_W-2:0], i_Data};
    assign w_fill_next   = (r_fill == c_fill_full) ? r_fill : r_fill + c_fill_one;

`ifdef SEQ_DETECT_MASK_EN
    assign w_diff = (w_window_next ^ i_Pattern) & ~i_Mask;
`else
    assign w_diff = w_window_next ^ i_Pattern;
`endif

    // A match needs a completely filled window on this very bit.
    assign w_hit = (w_fill_next == c_fill_full) && (w_diff == '0);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state  <= ST_IDLE;
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
            r_cnt    <= '0;
        end else if (i_Clear) begin
            // Clear wins over a simultaneous valid bit; that bit is dropped.
            r_state  <= ST_IDLE;
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_match <= 1'b0;
            if (i_Data_Vld) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_FILL;
                        r_window <= {{(PAT_W-1){1'b0}}, i_Data};
                        r_fill   <= c_fill_one;
                    end
                    // FILL, HUNT and MATCH share one advance rule. After a
                    // non-overlapping match the window was emptied, so the
                    // fill count naturally restarts and MATCH falls to FILL.
                    ST_FILL, ST_HUNT, ST_MATCH: begin
                        if (w_hit) begin
                            r_state <= ST_MATCH;
                            r_match <= 1'b1;
                            if (r_cnt != '1) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                            if (i_Overlap) begin
                                r_window <= w_window_next;
                                r_fill   <= w_fill_next;
                            end else begin
                                r_window <= '0;
                                r_fill   <= '0;
                            end
                        end else begin
                            r_state  <= (w_fill_next == c_fill_full) ? ST_HUNT : ST_FILL;
                            r_window <= w_window_next;
                            r_fill   <= w_fill_next;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_window <= '0;
                        r_fill   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_State     = r_state;
    assign o_Match     = r_match;
    assign o_Match_Cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_fsm
// Description : Directed self-checking bench for seq_detect_fsm. A second
//               instance with CNT_W=2 shares all inputs to exercise counter
//               saturation. Build with SEQ_DETECT_MASK_EN to add the mask case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_fsm;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Clear;
    logic       i_Data;
    logic       i_Data_Vld;
    logic [3:0] i_Pattern;
    logic       i_Overlap;
`ifdef SEQ_DETECT_MASK_EN
    logic [3:0] i_Mask;
`endif
    logic [1:0] o_State,  o_State2;
    logic       o_Match,  o_Match2;
    logic [7:0] o_Match_Cnt;
    logic [1:0] o_Match_Cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_Clk = ~i_Clk;

    seq_detect_fsm #(.PAT_W(4), .CNT_W(8)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Clear(i_Clear),
        .i_Data(i_Data), .i_Data_Vld(i_Data_Vld), .i_Pattern(i_Pattern),
`ifdef SEQ_DETECT_MASK_EN
        .i_Mask(i_Mask),
`endif
        .i_Overlap(i_Overlap), .o_State(o_State), .o_Match(o_Match),
        .o_Match_Cnt(o_Match_Cnt)
    );

    seq_detect_fsm #(.PAT_W(4), .CNT_W(2)) dut2 (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Clear(i_Clear),
        .i_Data(i_Data), .i_Data_Vld(i_Data_Vld), .i_Pattern(i_Pattern),
`ifdef SEQ_DETECT_MASK_EN
        .i_Mask(i_Mask),
`endif
        .i_Overlap(i_Overlap), .o_State(o_State2), .o_Match(o_Match2),
        .o_Match_Cnt(o_Match_Cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // All steps begin 1 time unit after a rising edge and end at the same phase.
    task automatic send_bit(input logic d);
        i_Data     = d;
        i_Data_Vld = 1'b1;
        @(posedge i_Clk); #1;
        i_Data_Vld = 1'b0;
    endtask

    task automatic idle(input int n);
        i_Data_Vld = 1'b0;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic do_clear();
        i_Clear = 1'b1;
        @(posedge i_Clk); #1;
        i_Clear = 1'b0;
    endtask

    logic [6:0] stream;
    logic [1:0] exp_st_ov  [7];
    logic [1:0] exp_st_nov [7];
    logic       exp_m_ov   [7];
    logic       exp_m_nov  [7];

    initial begin
        i_Rst = 1'b0; i_Clear = 1'b0; i_Data = 1'b0; i_Data_Vld = 1'b0;
        i_Pattern = 4'b1011; i_Overlap = 1'b1;
`ifdef SEQ_DETECT_MASK_EN
        i_Mask = 4'b0000;
`endif
        stream     = 7'b1011011;  // bit 6 sent first
        exp_st_ov  = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
        exp_m_ov   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_st_nov = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
        exp_m_nov  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge i_Clk); #1;
        chk("rst_state", 32'(o_State), 32'd0);
        chk("rst_match", 32'(o_Match), 32'd0);
        chk("rst_cnt",   32'(o_Match_Cnt), 32'd0);
        i_Rst = 1'b1;
        idle(10);
        chk("idle_state", 32'(o_State), 32'd0);
        chk("idle_match", 32'(o_Match), 32'd0);
        chk("idle_cnt",   32'(o_Match_Cnt), 32'd0);

        // Overlapping detection
        for (int i = 0; i < 7; i++) begin
            send_bit(stream[6-i]);
            chk($sformatf("ov_state_b%0d", i+1), 32'(o_State), 32'(exp_st_ov[i]));
            chk($sformatf("ov_match_b%0d", i+1), 32'(o_Match), 32'(exp_m_ov[i]));
        end
        chk("ov_cnt", 32'(o_Match_Cnt), 32'd2);
        idle(1);
        chk("ov_hold_state", 32'(o_State), 32'd3);
        chk("ov_no_repeat",  32'(o_Match), 32'd0);

        // Clear
        do_clear();
        chk("clr_state", 32'(o_State), 32'd0);
        chk("clr_cnt",   32'(o_Match_Cnt), 32'd0);

        // Non-overlapping detection
        i_Overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_bit(stream[6-i]);
            chk($sformatf("nov_state_b%0d", i+1), 32'(o_State), 32'(exp_st_nov[i]));
            chk($sformatf("nov_match_b%0d", i+1), 32'(o_Match), 32'(exp_m_nov[i]));
        end
        chk("nov_cnt", 32'(o_Match_Cnt), 32'd1);

        // Gapped valid bits
        do_clear();
        i_Overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_bit(stream[6-i]);
            chk($sformatf("gap_state_b%0d", i+1), 32'(o_State), (i == 3) ? 32'd3 : 32'd1);
            chk($sformatf("gap_match_b%0d", i+1), 32'(o_Match), (i == 3) ? 32'd1 : 32'd0);
            idle(3);
            chk($sformatf("gap_hold_b%0d", i+1), 32'(o_State), (i == 3) ? 32'd3 : 32'd1);
            chk($sformatf("gap_nomatch_b%0d", i+1), 32'(o_Match), 32'd0);
        end
        chk("gap_cnt", 32'(o_Match_Cnt), 32'd1);

        // Clear together with the completing bit
        do_clear();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i_Clear = 1'b1;
        send_bit(1'b1);
        i_Clear = 1'b0;
        chk("clrbit_state", 32'(o_State), 32'd0);
        chk("clrbit_match", 32'(o_Match), 32'd0);
        chk("clrbit_cnt",   32'(o_Match_Cnt), 32'd0);

        // Async reset mid-stream
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("pre_rst_state", 32'(o_State), 32'd1);
        i_Rst = 1'b0;
        #1;
        chk("async_rst_state", 32'(o_State), 32'd0);
        #2;
        i_Rst = 1'b1;
        @(posedge i_Clk); #1;
        send_bit(1'b0);
        chk("rst_b1_match", 32'(o_Match), 32'd0);
        send_bit(1'b1);
        chk("rst_b2_match", 32'(o_Match), 32'd0);
        send_bit(1'b1);
        chk("rst_b3_match", 32'(o_Match), 32'd0);
        chk("rst_b3_state", 32'(o_State), 32'd1);
        chk("rst_cnt_after", 32'(o_Match_Cnt), 32'd0);

        // Saturating counter on the CNT_W=2 instance
        do_clear();
        i_Pattern = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            chk($sformatf("sat_match_b%0d", i+1), 32'(o_Match2), (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("sat_cnt_b%0d", i+1), 32'(o_Match_Cnt2),
                (i < 3) ? 32'd0 : ((i - 2) > 3 ? 32'd3 : 32'(i - 2)));
        end
        chk("sat_state", 32'(o_State2), 32'd3);
        chk("wide_cnt",  32'(o_Match_Cnt), 32'd5);

`ifdef SEQ_DETECT_MASK_EN
        // Masked compare
        do_clear();
        i_Pattern = 4'b1011;
        i_Mask    = 4'b0100;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("mask_match", 32'(o_Match), 32'd1);
        chk("mask_cnt",   32'(o_Match_Cnt), 32'd1);
        do_clear();
        i_Mask = 4'b0000;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("nomask_match", 32'(o_Match), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
